// File: rtl/reg_file_sb_pkg.sv
// Shared constants for the LEGv8 register file: word width, XZR index,
// architectural register count and the packed-port slice helper.
package reg_file_sb_pkg;

    localparam int WORD       = 64;
    localparam int XZR        = 31;
    localparam int NREGS_ARCH = 32;
    localparam int REG_AW     = $clog2(NREGS_ARCH);

    // Low bit of port `port` in a bus packing `width`-bit fields side by side.
    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Per-register busy scoreboard: tracks one outstanding producer per register,
// answers allocation requests and reports busy status per read port.
module reg_scoreboard
    import reg_file_sb_pkg::*;
#(
    parameter int  NREGS    = NREGS_ARCH,
    parameter int  NRD      = 2,
    parameter int  ZERO_REG = XZR,
    parameter int  BYPASS   = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy,
    input  logic              wr0_en,
    input  logic [AW-1:0]     wr0_addr,
    input  logic              wr1_en,
    input  logic [AW-1:0]     wr1_addr,
    input  logic              alloc_en,
    input  logic [AW-1:0]     alloc_addr,
    output logic              alloc_ok,
    output logic [NREGS-1:0]  busy_vec
);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] clr;
    logic [NREGS-1:0] set;

    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < 32'(NREGS);
    endfunction

    always_comb begin
        clr = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            clr[i] = (wr0_en && wr0_addr == AW'(i)) || (wr1_en && wr1_addr == AW'(i));
        end
    end

    // A retiring producer frees the slot in the same cycle, so a new allocation may replace it.
    always_comb begin
        alloc_ok = 1'b1;
        if (in_range(alloc_addr) && alloc_addr != AW'(ZERO_REG)) begin
            alloc_ok = !busy[alloc_addr] || clr[alloc_addr];
        end
    end

    always_comb begin
        set = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            set[i] = alloc_en && alloc_ok && alloc_addr == AW'(i) && i != unsigned'(ZERO_REG);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= set | (busy & ~clr);
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] a;
        assign a = rd_addr[slice_lo(k, AW) +: AW];
        assign rd_busy[k] = in_range(a) && a != AW'(ZERO_REG) && busy[a]
                            && !(BYPASS != 0 && clr[a]);
    end

    assign busy_vec = busy;

endmodule

// File: rtl/reg_file_sb.sv
// LEGv8 integer register file: two write ports (ALU writeback, load return),
// combinational read ports with optional same-cycle bypass, XZR reads zero.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int  WIDTH    = WORD,
    parameter int  NREGS    = NREGS_ARCH,
    parameter int  NRD      = 2,
    parameter int  ZERO_REG = XZR,
    parameter int  BYPASS   = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*WIDTH-1:0] rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic                 wr0_en,
    input  logic [AW-1:0]        wr0_addr,
    input  logic [WIDTH-1:0]     wr0_data,
    input  logic                 wr1_en,
    input  logic [AW-1:0]        wr1_addr,
    input  logic [WIDTH-1:0]     wr1_data,
    input  logic                 alloc_en,
    input  logic [AW-1:0]        alloc_addr,
    output logic                 alloc_ok,
    output logic [NREGS-1:0]     busy_vec
);

    logic [WIDTH-1:0] regs [NREGS];
    logic             wr0_ok;
    logic             wr1_ok;

    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < 32'(NREGS);
    endfunction

    assign wr0_ok = wr0_en && in_range(wr0_addr) && wr0_addr != AW'(ZERO_REG);
    assign wr1_ok = wr1_en && in_range(wr1_addr) && wr1_addr != AW'(ZERO_REG);

    // wr1 is applied last so it wins when both ports target one register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr0_ok) regs[wr0_addr] <= wr0_data;
            if (wr1_ok) regs[wr1_addr] <= wr1_data;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] d;
        assign a = rd_addr[slice_lo(k, AW) +: AW];

        always_comb begin
            d = '0;
            if (in_range(a) && a != AW'(ZERO_REG)) begin
                if (BYPASS != 0 && wr1_en && wr1_addr == a) begin
                    d = wr1_data;
                end else if (BYPASS != 0 && wr0_en && wr0_addr == a) begin
                    d = wr0_data;
                end else begin
                    d = regs[a];
                end
            end
        end

        assign rd_data[slice_lo(k, WIDTH) +: WIDTH] = d;
    end

    reg_scoreboard #(
        .NREGS    (NREGS),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr    (rd_addr),
        .rd_busy    (rd_busy),
        .wr0_en     (wr0_en),
        .wr0_addr   (wr0_addr),
        .wr1_en     (wr1_en),
        .wr1_addr   (wr1_addr),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .alloc_ok   (alloc_ok),
        .busy_vec   (busy_vec)
    );

endmodule
